// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the N-port memory arbiter:
//   - state_t   : arbiter FSM encoding (IDLE, ISSUE, WAIT_RD, RESP)
//   - RW_WRITE / RW_READ : direction encoding used on req_rw and rw
//   - MAX_PORTS : upper bound on NPORTS; grant indices are 3 bits wide
// Optional build macro ARB_PRIO0_EN (consumed by rr_select) gives port 0
// absolute priority.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int MAX_PORTS = 8;
   localparam int GID_W     = 3;    // enough to index MAX_PORTS ports

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      RESP    = 2'd3
   } state_t;

endpackage : mem_arb_pkg

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational grant selector for mem_arbiter_n.
//   req        [NPORTS-1:0] in  : request vector
//   last_grant [2:0]        in  : port granted in the previous arbitration
//   hold_ok                 in  : last_grant is requesting and still has hold
//                                 budget left, so it is re-granted
//   grant      [2:0]        out : selected port (meaningful only when |req)
// Without a hold, the search is round-robin starting at last_grant+1 and
// wrapping, so last_grant itself is the lowest priority.
// Build macro ARB_PRIO0_EN: a requesting port 0 overrides round-robin and hold.
// -----------------------------------------------------------------------------
module rr_select
   import mem_arb_pkg::*;
#(
   parameter int NPORTS = 2
) (
   input  logic [NPORTS-1:0] req,
   input  logic [GID_W-1:0]  last_grant,
   input  logic              hold_ok,
   output logic [GID_W-1:0]  grant
);

   // Widening to MAX_PORTS lets a 3-bit index address the vector for any NPORTS.
   logic [MAX_PORTS-1:0] req_pad;
   int unsigned          cand;
   logic                 found;

   assign req_pad = MAX_PORTS'(req);

   always_comb begin
      // NOTE: every variable written here gets a default first, otherwise
      // paths that skip an assignment would infer a latch.
      grant = last_grant;
      found = 1'b0;
      cand  = 0;

      // Round-robin: walk forward from the port after the last grant.
      for (int k = 1; k <= NPORTS; k++) begin
         cand = (32'(last_grant) + 32'(k)) % 32'(NPORTS);
         if (!found && req_pad[cand[GID_W-1:0]]) begin
            grant = cand[GID_W-1:0];
            found = 1'b1;
         end
      end

      // Hold budget remaining: stay on the current owner.
      if (hold_ok) begin
         grant = last_grant;
      end

`ifdef ARB_PRIO0_EN
      // Port 0 wins any arbitration it takes part in.
      if (req_pad[0]) begin
         grant = '0;
      end
`else
      // All ports arbitrated by round-robin and hold alone.
`endif
   end

endmodule : rr_select

// File: rtl/mem_arbiter_n.sv
// -----------------------------------------------------------------------------
// mem_arbiter_n
// Arbitrates NPORTS requestors onto a single memory-controller command port.
// One transaction is in flight at a time:
//   IDLE    -> pick a port, latch its addr/rw/wdata
//   ISSUE   -> present the command (in_valid) until busy is low
//   WAIT_RD -> reads only: wait for the first out_valid, capture data_out
//   RESP    -> one-cycle req_ack to the granted port
//
// Parameters: NPORTS (2..8), AW address width, DW data width,
//             HOLD (1..15) max consecutive grants to one port.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_rw [NPORTS]      per-port request and direction (1 = write)
//   req_addr  [NPORTS*AW]          per-port address, port i at [i*AW +: AW]
//   req_wdata [NPORTS*DW]          per-port write data, sliced like req_addr
//   req_ack   [NPORTS]             one-cycle completion pulse per port
//   rsp_rdata [DW]                 read data, valid while req_ack is high
//   user_addr, rw, data_in, in_valid   command to the controller
//   busy, data_out, out_valid          status / read data from the controller
//   grant_id [3]                   currently granted port
//   grant_active                   a transaction is in flight
// Build macro ARB_PRIO0_EN: port 0 has absolute priority (see rr_select).
// -----------------------------------------------------------------------------
module mem_arbiter_n
   import mem_arb_pkg::*;
#(
   parameter int NPORTS = 2,
   parameter int AW     = 23,
   parameter int DW     = 32,
   parameter int HOLD   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NPORTS-1:0]    req_valid,
   input  logic [NPORTS*AW-1:0] req_addr,
   input  logic [NPORTS-1:0]    req_rw,
   input  logic [NPORTS*DW-1:0] req_wdata,
   output logic [NPORTS-1:0]    req_ack,
   output logic [DW-1:0]        rsp_rdata,
   output logic [AW-1:0]        user_addr,
   output logic                 rw,
   output logic [DW-1:0]        data_in,
   output logic                 in_valid,
   input  logic                 busy,
   input  logic [DW-1:0]        data_out,
   input  logic                 out_valid,
   output logic [2:0]           grant_id,
   output logic                 grant_active
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t           state_q,    state_d;
   logic [GID_W-1:0] grant_q,    grant_d;
   logic [3:0]       hold_cnt_q, hold_cnt_d;
   logic             granted_q,  granted_d;   // any grant made since reset
   logic [AW-1:0]    addr_q,     addr_d;
   logic             rw_q,       rw_d;
   logic [DW-1:0]    wdata_q,    wdata_d;
   logic [DW-1:0]    rdata_q,    rdata_d;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic [MAX_PORTS-1:0] req_pad;
   logic                 hold_ok;
   logic [GID_W-1:0]     sel;

   assign req_pad = MAX_PORTS'(req_valid);

   // The reset value of grant_q only steers round-robin to port 0 first; it
   // is not a real previous owner, so no hold applies until a grant is made.
   assign hold_ok = granted_q
                    && req_pad[grant_q]
                    && (32'(hold_cnt_q) < 32'(HOLD - 1));

   rr_select #(
      .NPORTS (NPORTS)
   ) u_rr_select (
      .req        (req_valid),
      .last_grant (grant_q),
      .hold_ok    (hold_ok),
      .grant      (sel)
   );

   // ---------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      hold_cnt_d = hold_cnt_q;
      granted_d  = granted_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;

      unique case (state_q)
         IDLE: begin
            // Port fields are sampled here only; requestors keep them stable
            // until ack, so later changes cannot affect the transaction.
            if (|req_valid) begin
               grant_d    = sel;
               granted_d  = 1'b1;
               hold_cnt_d = (hold_ok && (sel == grant_q)) ? hold_cnt_q + 4'd1 : 4'd0;
               addr_d     = req_addr[int'(sel)*AW +: AW];
               rw_d       = req_rw[sel];
               wdata_d    = req_wdata[int'(sel)*DW +: DW];
               state_d    = ISSUE;
            end
         end

         ISSUE: begin
            if (!busy) begin
               state_d = (rw_q == RW_WRITE) ? RESP : WAIT_RD;
            end
         end

         WAIT_RD: begin
            if (out_valid) begin
               rdata_d = data_out;
               state_d = RESP;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   // NOTE: the command and read-data registers are reset too, because their
   // values are visible on outputs straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= GID_W'(NPORTS - 1);
         hold_cnt_q <= '0;
         granted_q  <= 1'b0;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         hold_cnt_q <= hold_cnt_d;
         granted_q  <= granted_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   always_comb begin
      req_ack = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if ((state_q == RESP) && (grant_q == GID_W'(i))) begin
            req_ack[i] = 1'b1;
         end
      end
   end

   assign in_valid     = (state_q == ISSUE);
   assign grant_active = (state_q != IDLE);
   assign user_addr    = addr_q;
   assign rw           = rw_q;
   assign data_in      = wdata_q;
   assign rsp_rdata    = rdata_q;
   assign grant_id     = grant_q;

endmodule : mem_arbiter_n
